// File: rtl/intsrcmux_pkg.sv
// Shared codes for the interrupt source concentrator: PerInt ops, command codes
// and the handshake FSM encoding.
package intsrcmux_pkg;
  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  localparam logic [1:0] CMDCLAIM = 2'b00;
  localparam logic [1:0] CMDENA   = 2'b01;
  localparam logic [1:0] CMDMODE  = 2'b10;
  localparam logic [1:0] CMDPEND  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RQST    = 2'b01,
    ST_WAITRDY = 2'b10,
    ST_CLAIMED = 2'b11
  } state_t;
endpackage

// File: rtl/intsrcmux_rrpick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i,
// wrapping from N-1 back to 0.
module intsrcmux_rrpick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  localparam int JW = IW + 1;

  logic [JW-1:0] j;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr_i} + JW'(k);
      if (j >= JW'(N)) j = j - JW'(N);
      if (req_i[j[IW-1:0]]) begin
        idx_o = j[IW-1:0];
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intsrcmux.sv
// Interrupt source concentrator: per-line enable, optional edge capture
// (INTSRCMUX_EDGE_EN), round-robin pick, request/ready handshake, PerInt claim.
module intsrcmux
  import intsrcmux_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int LINECOUNT = 0
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [1:0]                                    pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]      pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                          pi1_data_i,
  output logic [ARCHBITSZ-1:0]                          pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]                        pi1_sel_i,
  output logic                                          pi1_rdy_o,
  output logic [ARCHBITSZ-1:0]                          pi1_mapsz_o,
  input  logic [LINECOUNT-1:0]                          irq_i,
  output logic                                          intrqst_o,
  input  logic                                          intrdy_i
);
  localparam int IDXW = (LINECOUNT > 1) ? $clog2(LINECOUNT) : 1;
  localparam int ARGW = ARCHBITSZ - 3;
  localparam logic [ARGW-1:0]      LCNT     = ARGW'(LINECOUNT);
  localparam logic [ARCHBITSZ-1:0] RES_NONE = '1;
  localparam logic [ARCHBITSZ-1:0] RES_BUSY = {{(ARCHBITSZ-1){1'b1}}, 1'b0};
`ifdef INTSRCMUX_EDGE_EN
  localparam bit MODE_OK = 1'b1;
`else
  localparam bit MODE_OK = 1'b0;
`endif

  state_t                 state_q;
  logic [IDXW-1:0]        rrptr_q, sel_q, claimed_q, pick_idx, nxt_claim;
  logic [LINECOUNT-1:0]   en_q, pending;
  logic [ARCHBITSZ-1:0]   data_q, res, pcnt;
  logic                   pick_any, rw, idx_ok, cmd_bit, take;
  logic [1:0]             cmd;
  logic [ARGW-1:0]        cmd_idx;
  logic [IDXW-1:0]        cmd_line;
  logic                   unused_ok;

  assign unused_ok   = ^{pi1_addr_i, pi1_sel_i};
  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = ARCHBITSZ'(((ARCHBITSZ < 64) ? (64 / ARCHBITSZ) : 1) * (ARCHBITSZ / 8));
  assign pi1_data_o  = data_q;

  assign rw       = (pi1_op_i == PIRWOP);
  assign cmd      = pi1_data_i[1:0];
  assign cmd_bit  = pi1_data_i[2];
  assign cmd_idx  = pi1_data_i[ARCHBITSZ-1:3];
  assign cmd_line = cmd_idx[IDXW-1:0];
  assign idx_ok   = (cmd_idx < LCNT);

  assign take      = (state_q == ST_RQST) && pending[sel_q] && !intrdy_i;
  assign nxt_claim = (claimed_q == IDXW'(LINECOUNT - 1)) ? '0 : claimed_q + 1'b1;
  // Combinational on purpose: the controller registers intrdy_i, so no loop.
  assign intrqst_o = (state_q == ST_RQST) && intrdy_i;

`ifdef INTSRCMUX_EDGE_EN
  logic [LINECOUNT-1:0] mode_q, sticky_q, prev_q, sticky_clr;

  assign sticky_clr = take ? (LINECOUNT'(1) << sel_q) : '0;
  assign pending    = en_q & ((mode_q & sticky_q) | (~mode_q & irq_i));

  // A rising edge in the same cycle as the claim clear keeps sticky set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q   <= '0;
      sticky_q <= '0;
      prev_q   <= '0;
    end else begin
      prev_q   <= irq_i;
      sticky_q <= (sticky_q & ~sticky_clr) | (irq_i & ~prev_q & mode_q);
      if (rw && cmd == CMDMODE && idx_ok) mode_q[cmd_line] <= cmd_bit;
    end
  end
`else
  assign pending = en_q & irq_i;
`endif

  intsrcmux_rrpick #(.N(LINECOUNT), .IW(IDXW)) u_pick (
    .req_i (pending),
    .ptr_i (rrptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < LINECOUNT; i++) pcnt = pcnt + ARCHBITSZ'(pending[i]);
  end

  // Result reflects the pre-edge state, so a claim racing WAITRDY->CLAIMED sees busy.
  always_comb begin
    res = data_q;
    case (cmd)
      CMDCLAIM: res = (state_q == ST_CLAIMED) ? ARCHBITSZ'(claimed_q) :
                      (state_q == ST_IDLE)    ? RES_NONE : RES_BUSY;
      CMDENA:   res = idx_ok ? {3'b000, cmd_idx} : RES_NONE;
      CMDMODE:  res = (idx_ok && MODE_OK) ? {3'b000, cmd_idx} : RES_NONE;
      default:  res = pcnt;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rrptr_q   <= '0;
      sel_q     <= '0;
      claimed_q <= '0;
      en_q      <= '0;
      data_q    <= '0;
    end else begin
      if (rw) begin
        data_q <= res;
        if (cmd == CMDENA && idx_ok) en_q[cmd_line] <= cmd_bit;
      end
      case (state_q)
        ST_IDLE:
          if (pick_any) begin
            sel_q   <= pick_idx;
            state_q <= ST_RQST;
          end
        ST_RQST:
          if (!pending[sel_q]) state_q <= ST_IDLE;
          else if (!intrdy_i) begin
            claimed_q <= sel_q;
            state_q   <= ST_WAITRDY;
          end
        ST_WAITRDY:
          if (intrdy_i) state_q <= ST_CLAIMED;
        default:
          if (rw && cmd == CMDCLAIM) begin
            state_q <= ST_IDLE;
            rrptr_q <= nxt_claim;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_intsrcmux.sv
// Directed bench for intsrcmux (LINECOUNT=4, ARCHBITSZ=16); command results go
// through an expected-value queue that is drained when the result appears.
module tb_intsrcmux;
  import intsrcmux_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  pi1_op_i = PINOOP;
  logic [14:0] pi1_addr_i = '0;
  logic [15:0] pi1_data_i = '0;
  logic [15:0] pi1_data_o;
  logic [1:0]  pi1_sel_i = '0;
  logic        pi1_rdy_o;
  logic [15:0] pi1_mapsz_o;
  logic [3:0]  irq_i = '0;
  logic        intrqst_o;
  logic        intrdy_i = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  intsrcmux #(.ARCHBITSZ(16), .LINECOUNT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i),
    .pi1_data_i(pi1_data_i), .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i),
    .pi1_rdy_o(pi1_rdy_o), .pi1_mapsz_o(pi1_mapsz_o), .irq_i(irq_i),
    .intrqst_o(intrqst_o), .intrdy_i(intrdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ia(input int idx, input bit b);
    logic [12:0] i13;
    i13 = idx[12:0];
    return {i13, b};
  endfunction

  task automatic cmd(input logic [1:0] c, input logic [13:0] arg, input logic [15:0] exp,
                     input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    pi1_op_i   = PIRWOP;
    pi1_data_i = {arg, c};
    tick();
    pi1_op_i   = PINOOP;
    pi1_data_i = '0;
    chk(tag_q.pop_front(), pi1_data_o, exp_q.pop_front());
  endtask

  task automatic handshake(input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    while (!intrqst_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rq"}, 16'(intrqst_o), 16'd1);
    intrdy_i = 1'b0;
    tick();
    intrdy_i = 1'b1;
    tick();
    cmd(CMDCLAIM, '0, exp, tag);
  endtask

  initial begin
    #2;
    chk("rst_rqst", 16'(intrqst_o), 16'd0);
    chk("rst_data", pi1_data_o, 16'h0000);
    chk("rdy", 16'(pi1_rdy_o), 16'd1);
    chk("mapsz", pi1_mapsz_o, 16'd8);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick();

    // level request, handshake and claim
    cmd(CMDENA, ia(2, 1), 16'd2, "ena2");
    irq_i = 4'b0100;
    chk("rq_idle", 16'(intrqst_o), 16'd0);
    tick();
    chk("rq_1cyc", 16'(intrqst_o), 16'd1);
    intrdy_i = 1'b0;
    #1 chk("rq_ack_drop", 16'(intrqst_o), 16'd0);
    tick();
    irq_i = 4'b0000;
    intrdy_i = 1'b1;
    chk("rq_waitrdy", 16'(intrqst_o), 16'd0);
    tick();
    chk("rq_claimed", 16'(intrqst_o), 16'd0);
    cmd(CMDCLAIM, '0, 16'd2, "claim2");
    cmd(CMDCLAIM, '0, 16'hFFFF, "claim_idle");

    // async reset while waiting for ready
    cmd(CMDENA, ia(2, 1), 16'd2, "ena2b");
    irq_i = 4'b0100;
    tick();
    chk("rq2", 16'(intrqst_o), 16'd1);
    intrdy_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_async_rq", 16'(intrqst_o), 16'd0);
    chk("rst_async_data", pi1_data_o, 16'h0000);
    intrdy_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    chk("rst_no_rq", 16'(intrqst_o), 16'd0);
    cmd(CMDPEND, '0, 16'd0, "pend_en_clr");
    cmd(CMDCLAIM, '0, 16'hFFFF, "claim_after_rst");

    // round-robin between lines 0 and 3
    irq_i = 4'b1001;
    cmd(CMDENA, ia(0, 1), 16'd0, "ena0");
    cmd(CMDENA, ia(3, 1), 16'd3, "ena3");
    handshake(16'd0, "rr0");
    handshake(16'd3, "rr1");
    handshake(16'd0, "rr2");
    handshake(16'd3, "rr3");

    // busy claim, bad index, withdraw on disable
    tick();
    chk("rq_again", 16'(intrqst_o), 16'd1);
    cmd(CMDCLAIM, '0, 16'hFFFE, "claim_rqst");
    cmd(CMDENA, ia(4, 1), 16'hFFFF, "ena_oob");
    cmd(CMDENA, ia(0, 0), 16'd0, "dis0");
    chk("rq_still", 16'(intrqst_o), 16'd1);
    tick();
    chk("rq_withdraw", 16'(intrqst_o), 16'd0);
    handshake(16'd3, "repick3");

    // pending count
    irq_i = 4'b0110;
    cmd(CMDENA, ia(3, 0), 16'd3, "dis3");
    cmd(CMDENA, ia(1, 1), 16'd1, "ena1");
    cmd(CMDENA, ia(2, 1), 16'd2, "ena2c");
    cmd(CMDPEND, '0, 16'd2, "pend2");

    irq_i = 4'b0000;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
`ifdef INTSRCMUX_EDGE_EN
    cmd(CMDMODE, ia(1, 1), 16'd1, "mode1_edge");
    cmd(CMDENA, ia(1, 1), 16'd1, "ena1_edge");
    irq_i[1] = 1'b1;
    tick();
    irq_i[1] = 1'b0;
    handshake(16'd1, "edge_claim");
    cmd(CMDPEND, '0, 16'd0, "edge_pend0");
`else
    cmd(CMDMODE, ia(1, 1), 16'hFFFF, "mode_absent");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
